// File: rtl/polyveck_pack_eta.sv
// Streams a captured K-polynomial vector as 4-bit (ETA - coeff) nibbles, two per byte,
// over a valid/ready byte interface. It flags any coefficient outside [-ETA, ETA].
module polyveck_pack_eta #(
  parameter int K   = 6,
  parameter int ETA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [K*8192-1:0]  v_in,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned NBYTES = K * 128;
  localparam int unsigned CW     = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
  localparam logic signed [31:0] ETA_S = 32'(ETA);
  localparam logic signed [31:0] NEG_ETA_S = -ETA_S;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            capture;
  logic            stream;
  logic            xfer;
  logic            is_last;

  // Byte b consumes coefficients 2b and 2b+1 of the flattened vector, which sit
  // contiguously in v_in. Each captured entry is therefore one byte's 64-bit pair.
  logic [63:0]        pair_q [NBYTES];
  logic [63:0]        pair;
  logic signed [31:0] c_lo;
  logic signed [31:0] c_hi;
  logic [3:0]         nib_lo;
  logic [3:0]         nib_hi;
  logic               oor;

  assign capture = (state_q == IDLE) && start;
  assign stream  = (state_q == STREAM);
  assign xfer    = stream && out_ready;
  assign is_last = (cnt_q == LAST);

  always_ff @(posedge clock) begin
    if (capture) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        pair_q[i] <= v_in[64*i +: 64];
      end
    end
  end

  assign pair   = pair_q[cnt_q];
  assign c_lo   = pair[31:0];
  assign c_hi   = pair[63:32];
  assign nib_lo = 4'(ETA_S - c_lo);
  assign nib_hi = 4'(ETA_S - c_hi);
  assign oor    = (c_lo < NEG_ETA_S) || (c_lo > ETA_S) ||
                  (c_hi < NEG_ETA_S) || (c_hi > ETA_S);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (xfer && is_last) state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cnt_q <= '0;
        err   <= 1'b0;
      end else if (xfer) begin
        cnt_q <= cnt_q + 1'b1;
        if (oor) err <= 1'b1;
      end
    end
  end

  assign out_valid = stream;
  assign busy      = stream;
  assign done      = (state_q == DONE);
  assign out_last  = stream && is_last;
  assign out_data  = stream ? {nib_hi, nib_lo} : '0;

endmodule
